// File: rtl/sn_gen_ctrl.sv
// Command sequencer for a bank of stochastic number generators:
// loads seeds/thresholds over a shared bus and runs timed EN bursts.
module sn_gen_ctrl #(
  parameter int NUM_GEN = 8,
  parameter int SEL_W   = 8,
  parameter int OUT_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [1:0]         CMD_OP,
  input  logic [SEL_W-1:0]   CMD_SEL,
  input  logic [31:0]        CMD_DATA,
  input  logic               ABORT,
  output logic [31:0]        DATA_OUT,
  output logic [NUM_GEN-1:0] SEED_WE,
  output logic [NUM_GEN-1:0] COMP_WE,
  output logic               EN,
  output logic               SN_VALID,
  output logic               BUSY,
  output logic               DONE,
  output logic               CMD_ERR,
  output logic [31:0]        EN_COUNT
);

  localparam int LW = (OUT_LAT < 1) ? 1 : OUT_LAT;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RUN, S_DRAIN, S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic [NUM_GEN-1:0] seed_q, seed_d;
  logic [NUM_GEN-1:0] comp_q, comp_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        drn_q, drn_d;
  logic [LW-1:0]      sr_q, sr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               in_range;
  logic [NUM_GEN-1:0] onehot;

  assign CMD_READY = (state_q == S_IDLE) & ~RST;
  assign EN        = (state_q == S_RUN) & ~ABORT;
  assign accept    = CMD_VALID & CMD_READY;
  assign in_range  = 32'(CMD_SEL) < 32'(NUM_GEN);
  assign onehot    = NUM_GEN'(1) << CMD_SEL;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    seed_d  = '0;
    comp_d  = '0;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    drn_d   = drn_q;
    sr_d    = LW'({sr_q, EN});
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (CMD_OP)
            2'd0, 2'd1: begin
              if (in_range) begin
                state_d = S_WRITE;
                data_d  = CMD_DATA;
                if (CMD_OP == 2'd0) seed_d = onehot;
                else                comp_d = onehot;
              end else begin
                err_d = 1'b1;
              end
            end
            2'd2: begin
              cnt_d = '0;
              if (CMD_DATA == '0) begin
                state_d = S_FIN;
                done_d  = 1'b1;
              end else begin
                rem_d   = CMD_DATA;
                state_d = S_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_RUN: begin
        if (ABORT) begin
          state_d = S_IDLE;
          sr_d    = '0;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            if (OUT_LAT == 0) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              state_d = S_DRAIN;
              drn_d   = 32'(OUT_LAT - 1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (ABORT) begin
          state_d = S_IDLE;
          sr_d    = '0;
        end else if (drn_q == '0) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          drn_d = drn_q - 32'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) | (state_d == S_DRAIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      seed_q  <= '0;
      comp_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      drn_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      seed_q  <= seed_d;
      comp_q  <= comp_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      drn_q   <= drn_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign DATA_OUT = data_q;
  assign SEED_WE  = seed_q;
  assign COMP_WE  = comp_q;
  assign SN_VALID = (OUT_LAT == 0) ? EN : sr_q[LW-1];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign CMD_ERR  = err_q;
  assign EN_COUNT = cnt_q;

endmodule

// File: tb/tb_sn_gen_ctrl.sv
// Directed bench for sn_gen_ctrl: load table, run bursts,
// abort, and back-to-back commands with a mid-run reset.
module tb_sn_gen_ctrl;

  localparam int LAT = 2;

  logic        CLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [7:0]  CMD_SEL;
  logic [31:0] CMD_DATA;
  logic        ABORT;
  logic [31:0] DATA_OUT;
  logic [7:0]  SEED_WE;
  logic [7:0]  COMP_WE;
  logic        EN;
  logic        SN_VALID;
  logic        BUSY;
  logic        DONE;
  logic        CMD_ERR;
  logic [31:0] EN_COUNT;

  sn_gen_ctrl #(.NUM_GEN(8), .SEL_W(8), .OUT_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_SEL(CMD_SEL), .CMD_DATA(CMD_DATA),
    .ABORT(ABORT), .DATA_OUT(DATA_OUT),
    .SEED_WE(SEED_WE), .COMP_WE(COMP_WE),
    .EN(EN), .SN_VALID(SN_VALID), .BUSY(BUSY),
    .DONE(DONE), .CMD_ERR(CMD_ERR), .EN_COUNT(EN_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  sel;
    logic [31:0] data;
    logic [7:0]  seed;
    logic [7:0]  comp;
    logic        err;
    logic        rdy;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl [7];

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_en"},    32'(EN), 32'd0);
    chk({nm, "_sv"},    32'(SN_VALID), 32'd0);
    chk({nm, "_busy"},  32'(BUSY), 32'd0);
    chk({nm, "_done"},  32'(DONE), 32'd0);
    chk({nm, "_err"},   32'(CMD_ERR), 32'd0);
    chk({nm, "_seed"},  32'(SEED_WE), 32'd0);
    chk({nm, "_comp"},  32'(COMP_WE), 32'd0);
  endtask

  task automatic run_check(input int l);
    int dcyc;
    int exp_cnt;
    @(negedge CLK);
    chk($sformatf("run%0d_rdy_pre", l), 32'(CMD_READY), 32'd1);
    CMD_OP    = 2'd2;
    CMD_SEL   = 8'd0;
    CMD_DATA  = 32'(l);
    CMD_VALID = 1'b1;
    dcyc = (l == 0) ? 1 : l + LAT + 1;
    for (int c = 1; c <= dcyc + 1; c++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      exp_cnt = (l == 0) ? 0 : ((c - 1 < l) ? c - 1 : l);
      chk($sformatf("run%0d_en_c%0d", l, c), 32'(EN),
          32'(c <= l));
      chk($sformatf("run%0d_sv_c%0d", l, c), 32'(SN_VALID),
          32'(c >= 1 + LAT && c <= l + LAT));
      chk($sformatf("run%0d_done_c%0d", l, c), 32'(DONE),
          32'(c == dcyc));
      chk($sformatf("run%0d_rdy_c%0d", l, c), 32'(CMD_READY),
          32'(c == dcyc + 1));
      chk($sformatf("run%0d_busy_c%0d", l, c), 32'(BUSY),
          32'(l > 0 && c <= l + LAT));
      chk($sformatf("run%0d_cnt_c%0d", l, c), EN_COUNT,
          32'(exp_cnt));
    end
  endtask

  initial begin
    tbl[0] = '{2'd0, 8'd3, 32'hDEADBEEF, 8'h08, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{2'd1, 8'd0, 32'h12345678, 8'h00, 8'h01, 1'b0, 1'b0, 32'h12345678};
    tbl[2] = '{2'd1, 8'd9, 32'hCAFEF00D, 8'h00, 8'h00, 1'b1, 1'b1, 32'h12345678};
    tbl[3] = '{2'd0, 8'd7, 32'hA5A5A5A5, 8'h80, 8'h00, 1'b0, 1'b0, 32'hA5A5A5A5};
    tbl[4] = '{2'd0, 8'd8, 32'h0BADC0DE, 8'h00, 8'h00, 1'b1, 1'b1, 32'hA5A5A5A5};
    tbl[5] = '{2'd1, 8'd5, 32'h0000FFFF, 8'h00, 8'h20, 1'b0, 1'b0, 32'h0000FFFF};
    tbl[6] = '{2'd3, 8'd2, 32'h77777777, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0000FFFF};

    RST = 1'b1;
    CMD_VALID = 1'b0;
    CMD_OP = 2'd3;
    CMD_SEL = 8'd0;
    CMD_DATA = 32'd0;
    ABORT = 1'b0;

    repeat (2) @(negedge CLK);
    chk_idle_outs("rst");
    chk("rst_dout", DATA_OUT, 32'd0);
    chk("rst_cnt", EN_COUNT, 32'd0);
    chk("rst_rdy", 32'(CMD_READY), 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      chk($sformatf("v%0d_rdy_pre", i), 32'(CMD_READY), 32'd1);
      CMD_OP    = tbl[i].op;
      CMD_SEL   = tbl[i].sel;
      CMD_DATA  = tbl[i].data;
      CMD_VALID = 1'b1;
      @(negedge CLK);
      CMD_VALID = 1'b0;
      chk($sformatf("v%0d_seed", i), 32'(SEED_WE), 32'(tbl[i].seed));
      chk($sformatf("v%0d_comp", i), 32'(COMP_WE), 32'(tbl[i].comp));
      chk($sformatf("v%0d_err", i), 32'(CMD_ERR), 32'(tbl[i].err));
      chk($sformatf("v%0d_rdy", i), 32'(CMD_READY), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_dout", i), DATA_OUT, tbl[i].dout);
      @(negedge CLK);
      chk($sformatf("v%0d_seed_off", i), 32'(SEED_WE), 32'd0);
      chk($sformatf("v%0d_comp_off", i), 32'(COMP_WE), 32'd0);
      chk($sformatf("v%0d_err_off", i), 32'(CMD_ERR), 32'd0);
      chk($sformatf("v%0d_rdy_post", i), 32'(CMD_READY), 32'd1);
      chk($sformatf("v%0d_dout_hold", i), DATA_OUT, tbl[i].dout);
    end

    run_check(5);
    run_check(0);
    run_check(1);

    // Abort on the 10th EN cycle of a 100-cycle run.
    @(negedge CLK);
    CMD_OP = 2'd2;
    CMD_DATA = 32'd100;
    CMD_VALID = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      chk($sformatf("ab_en_c%0d", c), 32'(EN), 32'd1);
    end
    @(negedge CLK);
    ABORT = 1'b1;
    #1;
    chk("ab_en_drop", 32'(EN), 32'd0);
    chk("ab_cnt_at", EN_COUNT, 32'd9);
    chk("ab_sv_at", 32'(SN_VALID), 32'd1);
    @(negedge CLK);
    ABORT = 1'b0;
    chk("ab_sv_flush", 32'(SN_VALID), 32'd0);
    chk("ab_cnt_hold", EN_COUNT, 32'd9);
    chk("ab_rdy", 32'(CMD_READY), 32'd1);
    chk("ab_busy", 32'(BUSY), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk($sformatf("ab_nodone_%0d", c), 32'(DONE), 32'd0);
      chk($sformatf("ab_nosv_%0d", c), 32'(SN_VALID), 32'd0);
    end

    // Back-to-back with CMD_VALID held, then reset mid-run.
    @(negedge CLK);
    CMD_OP = 2'd0;
    CMD_SEL = 8'd2;
    CMD_DATA = 32'h11111111;
    CMD_VALID = 1'b1;
    chk("bb_rdy0", 32'(CMD_READY), 32'd1);
    @(negedge CLK);
    chk("bb_seed", 32'(SEED_WE), 32'h04);
    chk("bb_dout0", DATA_OUT, 32'h11111111);
    chk("bb_rdy1", 32'(CMD_READY), 32'd0);
    CMD_OP = 2'd1;
    CMD_SEL = 8'd4;
    CMD_DATA = 32'h22222222;
    @(negedge CLK);
    chk("bb_rdy2", 32'(CMD_READY), 32'd1);
    chk("bb_nostrobe2", 32'(SEED_WE | COMP_WE), 32'd0);
    chk("bb_dout2", DATA_OUT, 32'h11111111);
    @(negedge CLK);
    chk("bb_comp", 32'(COMP_WE), 32'h10);
    chk("bb_dout3", DATA_OUT, 32'h22222222);
    chk("bb_rdy3", 32'(CMD_READY), 32'd0);
    CMD_OP = 2'd2;
    CMD_SEL = 8'd0;
    CMD_DATA = 32'd3;
    @(negedge CLK);
    chk("bb_rdy4", 32'(CMD_READY), 32'd1);
    @(negedge CLK);
    chk("bb_run_en", 32'(EN), 32'd1);
    chk("bb_run_busy", 32'(BUSY), 32'd1);
    chk("bb_run_rdy", 32'(CMD_READY), 32'd0);
    chk("bb_run_cnt", EN_COUNT, 32'd0);
    CMD_OP = 2'd0;
    CMD_SEL = 8'd1;
    CMD_DATA = 32'h33333333;
    @(negedge CLK);
    chk("bb_run_en2", 32'(EN), 32'd1);
    chk("bb_run_cnt2", EN_COUNT, 32'd1);
    chk("bb_run_noseed", 32'(SEED_WE), 32'd0);
    RST = 1'b1;
    #1;
    chk("bb_rst_rdy", 32'(CMD_READY), 32'd0);
    @(negedge CLK);
    chk_idle_outs("bb_rst");
    chk("bb_rst_dout", DATA_OUT, 32'd0);
    chk("bb_rst_cnt", EN_COUNT, 32'd0);
    chk("bb_rst_rdy2", 32'(CMD_READY), 32'd0);
    RST = 1'b0;
    #1;
    chk("bb_post_rdy", 32'(CMD_READY), 32'd1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    chk("bb_post_seed", 32'(SEED_WE), 32'h02);
    chk("bb_post_dout", DATA_OUT, 32'h33333333);
    chk("bb_post_en", 32'(EN), 32'd0);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sn_gen_ctrl.md
# sn_gen_ctrl

Command-driven sequencer for a bank of `NUM_GEN` stochastic number generators (`sn_gen`) that share one 32-bit data bus.
- Accepts load-seed, load-threshold and run commands over a valid/ready handshake.
- Turns each command into the one-hot `SEED_WE`/`COMP_WE` strobes or the common `EN` burst the generators expect.
- Flags with `SN_VALID` the cycles on which the generators' registered `SN_OUT_P`/`SN_OUT_N` bits belong to the burst, then pulses `DONE`.
- Sits between the host register interface and the generator bank.

## Interface
Parameters:
- `NUM_GEN`, default 8: number of generators driven, range 1..256.
- `SEL_W`, default 8: width of the `CMD_SEL` field.
- `OUT_LAT`, default 2: cycles from an `EN` cycle to the matching valid stochastic output bit.

Ports:
- `CLK` input 1: clock.
- `RST` input 1: reset, synchronous and active-high.
- `CMD_VALID` input 1: command present.
- `CMD_READY` output 1: controller accepts a command this cycle.
- `CMD_OP` input 2: 0 = load seed, 1 = load threshold, 2 = run, 3 = nop.
- `CMD_SEL` input `SEL_W`: target generator index (load ops only).
- `CMD_DATA` input 32: seed or threshold word, or run length for run.
- `ABORT` input 1: cancels an active run.
- `DATA_OUT` output 32: shared bus to the generators' `DATA_IN`.
- `SEED_WE` output `NUM_GEN`: one-hot seed write strobe.
- `COMP_WE` output `NUM_GEN`: one-hot threshold write strobe.
- `EN` output 1: common LFSR advance enable.
- `SN_VALID` output 1: generator output bits are valid this cycle.
- `BUSY` output 1: run in progress (RUN or DRAIN).
- `DONE` output 1: one-cycle pulse, run finished normally.
- `CMD_ERR` output 1: one-cycle pulse, load with `CMD_SEL >= NUM_GEN`.
- `EN_COUNT` output 32: `EN` cycles issued in the current or last run.

## Operation
- States: IDLE, WRITE, RUN, DRAIN, FIN.
- Handshake: a command is accepted on a cycle where `CMD_VALID & CMD_READY`. `CMD_READY` = (state == IDLE) & ~`RST`. The controller captures `CMD_*` at acceptance.
- IDLE, op 0 or 1 with in-range sel: go to WRITE. In WRITE, `DATA_OUT` = captured data and exactly one bit `SEED_WE[sel]` (op 0) or `COMP_WE[sel]` (op 1) is high for one cycle. Then return to IDLE.
- IDLE, op 0 or 1 with `sel >= NUM_GEN`: command is accepted, `CMD_ERR` pulses the next cycle, no strobe fires, state stays IDLE.
- IDLE, op 2 with length L > 0: clear `EN_COUNT` and go to RUN.
  - RUN holds `EN` = 1 for exactly L consecutive cycles; `EN_COUNT` increments per `EN` cycle.
  - Then DRAIN for `OUT_LAT` cycles with `EN` = 0, then FIN.
- IDLE, op 2 with L = 0: go directly to FIN. No `EN`, no `SN_VALID`, `EN_COUNT` cleared to 0.
- IDLE, op 3: accepted with no effect.
- FIN: `DONE` = 1 for one cycle, then IDLE.
- `SN_VALID` = `EN` delayed by `OUT_LAT` cycles through a shift register. It is exactly L cycles high per run.
- `ABORT` in RUN or DRAIN:
  - Next state is IDLE; `EN` drops in the same cycle `ABORT` is sampled high (`EN` is `state == RUN & ~ABORT`).
  - The `SN_VALID` pipeline is flushed to 0 the next cycle.
  - No `DONE` pulse; `EN_COUNT` holds the count reached.
- `ABORT` in IDLE, WRITE or FIN: ignored.
- `DATA_OUT` holds its last value outside WRITE. The controller never drives `DATA_OUT` changes while any strobe is high.
- `EN_COUNT` saturates at 2^32-1. This cannot occur for L ≤ 2^32-1, but is stated for safety.
- Reset mid-operation: every state returns to IDLE the cycle after `RST` is sampled high, with all reset values below.

## Timing
- Reset values: state IDLE; `DATA_OUT` = 0; `SEED_WE` = 0; `COMP_WE` = 0; `EN` = 0; `SN_VALID` = 0; `BUSY` = 0; `DONE` = 0; `CMD_ERR` = 0; `EN_COUNT` = 0. `CMD_READY` = 0 while `RST` is high.
- Load command accepted at cycle t: strobe and data at t+1. `CMD_READY` = 0 at t+1, 1 again at t+2. Throughput is one load per 2 cycles.
- Run accepted at t (L > 0):
  - `EN` is high over t+1..t+L.
  - `SN_VALID` is high over t+1+`OUT_LAT`..t+L+`OUT_LAT`.
  - `DONE` pulses at t+L+`OUT_LAT`+1.
  - `CMD_READY` returns at t+L+`OUT_LAT`+2.
- Run with L = 0 accepted at t: `DONE` at t+1, `CMD_READY` at t+2.
- `BUSY` = 1 exactly when state is RUN or DRAIN.
- All outputs are registered except `CMD_READY` and `EN`.

## Test plan
- Reset, then seed load: `CMD_OP`=0, `CMD_SEL`=3, `CMD_DATA`=0xDEADBEEF accepted at t → `SEED_WE`=0x08 and `DATA_OUT`=0xDEADBEEF at t+1 only; `CMD_READY`=0 at t+1.
- Threshold load with `CMD_SEL`=9 (`NUM_GEN`=8) → no `COMP_WE` bit set, `CMD_ERR` pulse at t+1, `CMD_READY` stays 1.
- Run with L=5 accepted at t → `EN` high t+1..t+5, `SN_VALID` high t+3..t+7, `DONE` at t+8, `EN_COUNT`=5.
- Run with L=0 → no `EN`, no `SN_VALID`, `DONE` at t+1, `EN_COUNT`=0.
- Run with L=100, `ABORT` raised on the 10th `EN` cycle → `EN`=0 that cycle, `EN_COUNT`=9, no `DONE`, `SN_VALID` flushed, `CMD_READY`=1 the next cycle.
- Back-to-back commands with `CMD_VALID` held (seed, threshold, run L=3) plus `RST` asserted mid-RUN → each command accepted only while `CMD_READY` is high; the reset cycle forces all outputs to their reset values and IDLE.
